// File: rtl/poc_control_unit.sv
// Fetch/decode/execute sequencer for the POC datapath.
// Drives ALU selects, register loads and a req/ack memory handshake with watchdog.
module poc_control_unit #(
   parameter int NREG        = 8,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      instr,
   input  logic            lsb,
   input  logic            neg,
   input  logic            mem_ack,
   output logic [3:0]      alu_sel,
   output logic [3:0]      b_sel,
   output logic [NREG-1:0] reg_ld,
   output logic            ac_ld,
   output logic            ir_ld,
   output logic            mdr_ld,
   output logic            pc_inc,
   output logic            pc_ld,
   output logic            addr_sel,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            illegal,
   output logic            halted,
   output logic            err
);

   localparam int WDW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_SELB = 4'h2;
   localparam logic [3:0] OP_STAC = 4'h3;
   localparam logic [3:0] OP_LDM  = 4'h4;
   localparam logic [3:0] OP_STM  = 4'h5;
   localparam logic [3:0] OP_JMPN = 4'h6;
   localparam logic [3:0] OP_JMPL = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   // REG_LD is the second beat of a register write-back (reg_ld strobe)
   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_ALU,
      S_ALU_WB,
      S_REG_WB,
      S_REG_LD,
      S_MEM_WAIT,
      S_HALT,
      S_ERROR
   } state_e;

   state_e         state_q, state_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [3:0]     b_sel_q, b_sel_d;

   logic [3:0] op;
   logic [3:0] arg;
   logic       reg_ok;
   logic       alu_ok;
   logic       wd_expire;

   assign op        = instr[7:4];
   assign arg       = instr[3:0];
   assign reg_ok    = 32'(arg) < NREG;
   assign alu_ok    = (arg != 4'h0) && (arg < 4'hE);
   assign wd_expire = (32'(wd_q) + 32'd1) == MEM_TIMEOUT;
   assign b_sel     = b_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wd_q    <= '0;
         b_sel_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         b_sel_q <= b_sel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wd_d     = '0;
      b_sel_d  = b_sel_q;
      alu_sel  = 4'h0;
      reg_ld   = '0;
      ac_ld    = 1'b0;
      ir_ld    = 1'b0;
      mdr_ld   = 1'b0;
      pc_inc   = 1'b0;
      pc_ld    = 1'b0;
      addr_sel = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_rd = 1'b1;
               if (mem_ack) begin
                  ir_ld   = 1'b1;
                  pc_inc  = 1'b1;
                  state_d = S_DECODE;
               end else if (wd_expire) begin
                  state_d = S_ERROR;
               end else begin
                  wd_d = wd_q + WDW'(1);
               end
            end
            S_DECODE: begin
               state_d = S_FETCH;
               case (op)
                  OP_NOP: state_d = S_FETCH;
                  OP_ALU: begin
                     if (alu_ok) state_d = S_EXEC_ALU;
                     else        illegal = 1'b1;
                  end
                  OP_SELB: begin
                     if (reg_ok) b_sel_d = arg;
                     else        illegal = 1'b1;
                  end
                  OP_STAC: begin
                     if (reg_ok) state_d = S_REG_WB;
                     else        illegal = 1'b1;
                  end
                  OP_LDM: begin
                     mem_rd   = 1'b1;
                     addr_sel = 1'b1;
                     state_d  = S_MEM_WAIT;
                  end
                  OP_STM: begin
                     mem_wr   = 1'b1;
                     addr_sel = 1'b1;
                     state_d  = S_MEM_WAIT;
                  end
                  OP_JMPN: pc_ld = neg;
                  OP_JMPL: pc_ld = lsb;
                  OP_JMP:  pc_ld = 1'b1;
                  OP_HALT: state_d = S_HALT;
                  default: illegal = 1'b1;
               endcase
            end
            S_EXEC_ALU: begin
               alu_sel = arg;
               state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
               ac_ld   = 1'b1;
               state_d = S_FETCH;
            end
            S_REG_WB: begin
               alu_sel = 4'h1;
               state_d = S_REG_LD;
            end
            S_REG_LD: begin
               reg_ld  = {{(NREG-1){1'b0}}, 1'b1} << arg;
               state_d = S_FETCH;
            end
            S_MEM_WAIT: begin
               addr_sel = 1'b1;
               mem_rd   = (op == OP_LDM);
               mem_wr   = (op == OP_STM);
               if (mem_ack) begin
                  mdr_ld  = (op == OP_LDM);
                  state_d = S_FETCH;
               end else if (wd_expire) begin
                  state_d = S_ERROR;
               end else begin
                  wd_d = wd_q + WDW'(1);
               end
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err = 1'b1;
            default: state_d = S_ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_poc_control_unit.sv
// Directed bench for poc_control_unit: expected output vectors are queued per
// cycle and compared against the DUT outputs on the falling edge.
module tb_poc_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instr = 8'h00;
   logic       lsb = 1'b0;
   logic       neg = 1'b0;
   logic       mem_ack = 1'b0;
   logic [3:0] alu_sel;
   logic [3:0] b_sel;
   logic [7:0] reg_ld;
   logic       ac_ld, ir_ld, mdr_ld, pc_inc, pc_ld, addr_sel;
   logic       mem_rd, mem_wr, illegal, halted, err;

   poc_control_unit #(.NREG(8), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .instr(instr), .lsb(lsb), .neg(neg),
      .mem_ack(mem_ack), .alu_sel(alu_sel), .b_sel(b_sel), .reg_ld(reg_ld),
      .ac_ld(ac_ld), .ir_ld(ir_ld), .mdr_ld(mdr_ld), .pc_inc(pc_inc),
      .pc_ld(pc_ld), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .illegal(illegal), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   localparam logic [10:0] NONE = 11'h000;
   localparam logic [10:0] AC   = 11'h400;
   localparam logic [10:0] IR   = 11'h200;
   localparam logic [10:0] MDR  = 11'h100;
   localparam logic [10:0] PCI  = 11'h080;
   localparam logic [10:0] PCL  = 11'h040;
   localparam logic [10:0] AS   = 11'h020;
   localparam logic [10:0] RD   = 11'h010;
   localparam logic [10:0] WR   = 11'h008;
   localparam logic [10:0] ILL  = 11'h004;
   localparam logic [10:0] HLT  = 11'h002;
   localparam logic [10:0] ERR  = 11'h001;

   logic [26:0] exp_q[$];
   string       tag_q[$];
   int          nerr = 0;
   int          nchk = 0;
   logic [3:0]  bs = 4'h0;
   logic [7:0]  cur = 8'h00;

   task automatic cyc(input string tag, input logic ack,
                      input logic [3:0] alu, input logic [7:0] rl,
                      input logic [10:0] fl);
      logic [26:0] got;
      logic [26:0] e;
      string       t;
      instr   = cur;
      mem_ack = ack;
      exp_q.push_back({alu, bs, rl, fl});
      tag_q.push_back(tag);
      @(negedge clk);
      got = {alu_sel, b_sel, reg_ld, ac_ld, ir_ld, mdr_ld, pc_inc, pc_ld,
             addr_sel, mem_rd, mem_wr, illegal, halted, err};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      nchk++;
      assert (got === e) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", t, got, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [7:0] ins, input int lat);
      for (int i = 1; i < lat; i++) cyc("fetch_wait", 1'b0, 4'h0, 8'h00, RD);
      cyc("fetch_ack", 1'b1, 4'h0, 8'h00, RD | IR | PCI);
      cur = ins;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      bs = 4'h0;
      cyc("reset", 1'b0, 4'h0, 8'h00, NONE);
      rst = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();

      // ALU op 9 after 3-cycle fetch latency
      fetch(8'h19, 4);
      cyc("dec_alu9", 1'b0, 4'h0, 8'h00, NONE);
      cyc("exec_alu9", 1'b0, 4'h9, 8'h00, NONE);
      cyc("wb_alu9", 1'b0, 4'h0, 8'h00, AC);

      // SELB 5 then STAC 3
      fetch(8'h25, 1);
      cyc("dec_selb5", 1'b0, 4'h0, 8'h00, NONE);
      bs = 4'h5;
      fetch(8'h33, 1);
      cyc("dec_stac3", 1'b0, 4'h0, 8'h00, NONE);
      cyc("regwb_alu1", 1'b0, 4'h1, 8'h00, NONE);
      cyc("regwb_ld3", 1'b0, 4'h0, 8'h08, NONE);
      fetch(8'h39, 1);
      cyc("dec_stac9_ill", 1'b0, 4'h0, 8'h00, ILL);
      fetch(8'h28, 1);
      cyc("dec_selb8_ill", 1'b0, 4'h0, 8'h00, ILL);
      fetch(8'h37, 2);
      cyc("dec_stac7", 1'b0, 4'h0, 8'h00, NONE);
      cyc("regwb7_alu1", 1'b0, 4'h1, 8'h00, NONE);
      cyc("regwb7_ld", 1'b0, 4'h0, 8'h80, NONE);

      // conditional jumps
      neg = 1'b1;
      lsb = 1'b0;
      fetch(8'h60, 1);
      cyc("jmpn_taken", 1'b0, 4'h0, 8'h00, PCL);
      fetch(8'h70, 1);
      cyc("jmpl_not", 1'b0, 4'h0, 8'h00, NONE);
      fetch(8'h80, 1);
      cyc("jmp", 1'b0, 4'h0, 8'h00, PCL);
      neg = 1'b0;
      lsb = 1'b1;
      fetch(8'h60, 1);
      cyc("jmpn_not", 1'b0, 4'h0, 8'h00, NONE);
      fetch(8'h70, 1);
      cyc("jmpl_taken", 1'b0, 4'h0, 8'h00, PCL);
      lsb = 1'b0;

      // LDM: mem_rd held 4 cycles, ack on the 4th
      fetch(8'h40, 1);
      cyc("ldm_dec", 1'b0, 4'h0, 8'h00, RD | AS);
      cyc("ldm_wait", 1'b0, 4'h0, 8'h00, RD | AS);
      cyc("ldm_wait", 1'b0, 4'h0, 8'h00, RD | AS);
      cyc("ldm_ack", 1'b1, 4'h0, 8'h00, RD | AS | MDR);
      fetch(8'h50, 1);
      cyc("stm_dec", 1'b0, 4'h0, 8'h00, WR | AS);
      cyc("stm_wait", 1'b0, 4'h0, 8'h00, WR | AS);
      cyc("stm_ack", 1'b1, 4'h0, 8'h00, WR | AS);

      // illegal encodings and a legal edge ALU function
      fetch(8'h10, 1);
      cyc("ill_10", 1'b0, 4'h0, 8'h00, ILL);
      fetch(8'h1E, 1);
      cyc("ill_1e", 1'b0, 4'h0, 8'h00, ILL);
      fetch(8'hA0, 1);
      cyc("ill_a0", 1'b0, 4'h0, 8'h00, ILL);
      fetch(8'h1D, 1);
      cyc("dec_alud", 1'b0, 4'h0, 8'h00, NONE);
      cyc("exec_alud", 1'b0, 4'hD, 8'h00, NONE);
      cyc("wb_alud", 1'b0, 4'h0, 8'h00, AC);
      fetch(8'h00, 1);
      cyc("nop", 1'b0, 4'h0, 8'h00, NONE);

      // ack on the 15th waiting cycle still completes
      fetch(8'h00, 15);
      cyc("late_ack_dec", 1'b0, 4'h0, 8'h00, NONE);

      // LDM watchdog boundary
      fetch(8'h40, 1);
      cyc("ldm_to_dec", 1'b0, 4'h0, 8'h00, RD | AS);
      for (int i = 0; i < 14; i++) cyc("ldm_to_wait", 1'b0, 4'h0, 8'h00, RD | AS);
      cyc("ldm_to_ack", 1'b1, 4'h0, 8'h00, RD | AS | MDR);

      // timeout: 15 unanswered cycles then ERROR
      for (int i = 0; i < 15; i++) cyc("to_wait", 1'b0, 4'h0, 8'h00, RD);
      cyc("error", 1'b0, 4'h0, 8'h00, ERR);
      cyc("error_ack", 1'b1, 4'h0, 8'h00, ERR);
      cyc("error_hold", 1'b0, 4'h0, 8'h00, ERR);

      // rst out of ERROR, then HALT
      do_reset();
      fetch(8'hF0, 2);
      cyc("halt_dec", 1'b0, 4'h0, 8'h00, NONE);
      for (int i = 0; i < 4; i++) cyc("halted", i[0], 4'h0, 8'h00, HLT);

      do_reset();
      cyc("post_rst_fetch", 1'b0, 4'h0, 8'h00, RD);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", nerr, nchk);
      $fatal(1, "bench timeout");
   end

endmodule
